pcal6416a_multi_ctrl: RTL
=========================

// Module: pcal6416a_multi_ctrl
// PURPOSE
//  Multi-device controller for PCAL6416A I2C I/O expanders sharing one i2c_basic master.
//  - Initialises each device's direction and interrupt mask.
//  - Writes output ports only when requested bits change.
//  - Reads input ports on the shared active-low INT line or on a poll timer.
//  - Arbitrates devices round-robin and flags NACKed devices.
// PARAMETERS
//  NUM_DEV   2       number of expanders, 1..8
//  POLL_DIV  1000000 clk cycles between forced reads of all devices; 0 = disable polling
//  SYNC_FF   2       synchroniser depth for irq_n, >=2
// PORTS
//  clk           in   1            system clock
//  reset         in   1            asynchronous, active-high reset
//  enable        in   1            0 = FSM holds state, no new transactions
//  start_init    in   1            pulse: (re)run init on all devices
//  dev_addr      in   7*NUM_DEV    7-bit I2C address per device, dev i at [7i+:7]
//  dir_inputs    in   16*NUM_DEV   1 = pin is input (config reg 0x06); mask = ~dir_inputs
//  out_req       in   16*NUM_DEV   requested output pin levels
//  irq_n         in   1            shared expander INT, active low, asynchronous
//  in_pins       out  16*NUM_DEV   last read input port value per device
//  in_valid      out  NUM_DEV      1-cycle pulse when dev i in_pins updates
//  dev_err       out  NUM_DEV      sticky: dev i NACKed; cleared by start_init
//  busy          out  1            FSM not in IDLE
//  i2c_start     out  1            1-cycle pulse starting a transaction
//  i2c_done      in   1            transaction complete, pulse or level
//  i2c_nack      in   1            valid with i2c_done: slave NACKed
//  i2c_addr      out  7            target address
//  num_wr_bytes  out  2            bytes to write, 0..3
//  wr_data0..2   out  8 each       write payload, byte 0 = register pointer
//  num_rd_bytes  out  2            bytes to read, 0..2
//  rd_data0..1   in   8 each       read payload: port0, port1
// BEHAVIOUR
//  Reset values:
//  - Outputs 0. Shadow regs and in_pins 0.
//  - pend_init = all 1: init runs automatically after reset.
//  - State IDLE.
//  Reset mid-transaction aborts immediately; i2c_basic must be reset by the same signal.
//  Per-device flags:
//  - pend_init: set by start_init.
//  - pend_rd: set on synchronised irq_n falling edge (all devices) or poll tick (all devices).
//  - pend_wr: set by out_req != shadow, evaluated every cycle.
//  States:
//  - IDLE -> ARB when any flag is set and enable = 1.
//  - ARB:
//    - Round-robin scan from last serviced dev+1 for the first dev with a flag.
//    - Priority within a dev: init > rd > wr.
//    - Latch i2c_addr and the operands.
//  - INIT_CFG: {0x06, dir[7:0], dir[15:8]} -> INIT_MASK: {0x4A, ~dir[7:0], ~dir[15:8]}
//    -> clear pend_init, set pend_rd and pend_wr for the dev.
//  - WRITE: {0x02, out_req[7:0], out_req[15:8]} captured in ARB.
//    On done, shadow <= captured value. Clear pend_wr only if out_req still equals the captured value.
//  - RD_PTR: write {0x00}, 1 byte -> RD_DATA: read 2 bytes.
//    On done: in_pins[dev] <= {rd_data1, rd_data0}, in_valid[dev] pulse, clear pend_rd.
//  - Each transaction state:
//    - Issues i2c_start on entry, cycle 1.
//    - Ignores i2c_done on that cycle.
//    - Waits for i2c_done from cycle 2 onward.
//    - Then returns to ARB, or IDLE if no flag is set.
//  - i2c_nack with done:
//    - Set dev_err[dev] and clear all of the dev's pend flags; the shadow is unchanged.
//    - Return to ARB.
//    - Devices with dev_err are skipped until start_init.
//  enable = 0:
//  - The in-flight transaction completes.
//  - The FSM then parks in ARB/IDLE. Flags keep accumulating.
//  Poll counter:
//  - Free-running modulo POLL_DIV; the tick is a 1-cycle pulse.
//  - A tick while a read is pending is absorbed, not queued twice.
//  irq edge and start_init in the same cycle: both flags are set; init services first.
//  i2c_start and wr_data/num_* are stable from the start pulse until i2c_done.
// TESTING
//  1. Reset, NUM_DEV=2, dir_inputs={16'h00FF,16'hFF00}:
//     - Expect writes 0x06 then 0x4A for each dev, in order dev0, dev1.
//     - Then read and write for each dev.
//     - busy falls after the last done.
//  2. Idle, out_req dev1 16'hA5A5 -> 16'h5AA5:
//     - Exactly one write {0x02,0xA5,0x5A} to dev1's address; no dev0 traffic.
//     - Holding out_req constant yields no further writes.
//  3. irq_n low, model returns 0x34,0x12:
//     - Read of both devices.
//     - in_pins dev0 = 16'h1234 with a 1-cycle in_valid[0] pulse.
//  4. Change out_req during the WRITE wait from 0x0001 to 0x0002:
//     - A second write with 0x0002 follows.
//     - Final shadow = 0x0002.
//  5. Model NACKs dev0 in INIT_CFG:
//     - dev_err=2'b01; dev0 is skipped; dev1 is serviced normally.
//     - start_init clears dev_err and retries dev0.
//  6. POLL_DIV=50, irq_n high: reads every 50 cycles, or as soon as the bus frees.
//     Assert reset mid-READ: all outputs 0 asynchronously, init reruns.

Source files
------------

// File: rtl/pcal6416a_multi_ctrl.sv
// Multi-device controller for PCAL6416A I/O expanders sharing one byte-oriented I2C master.
// Per device it sequences config/mask init, output-port writes on change and input-port reads
// on INT or poll tick, with round-robin arbitration and sticky NACK flags.
module pcal6416a_multi_ctrl #(
   parameter int unsigned NUM_DEV  = 2,
   parameter int unsigned POLL_DIV = 1000000,
   parameter int unsigned SYNC_FF  = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic                    start_init_i,
   input  logic [7*NUM_DEV-1:0]    dev_addr_i,
   input  logic [16*NUM_DEV-1:0]   dir_inputs_i,
   input  logic [16*NUM_DEV-1:0]   out_req_i,
   input  logic                    irq_n_i,
   output logic [16*NUM_DEV-1:0]   in_pins_o,
   output logic [NUM_DEV-1:0]      in_valid_o,
   output logic [NUM_DEV-1:0]      dev_err_o,
   output logic                    busy_o,
   output logic                    i2c_start_o,
   input  logic                    i2c_done_i,
   input  logic                    i2c_nack_i,
   output logic [6:0]              i2c_addr_o,
   output logic [1:0]              num_wr_bytes_o,
   output logic [7:0]              wr_data0_o,
   output logic [7:0]              wr_data1_o,
   output logic [7:0]              wr_data2_o,
   output logic [1:0]              num_rd_bytes_o,
   input  logic [7:0]              rd_data0_i,
   input  logic [7:0]              rd_data1_i
);

   localparam int unsigned DW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

   typedef enum logic [2:0] {
      StIdle, StArb, StInitCfg, StInitMask, StWrite, StRdPtr, StRdData
   } state_e;

   state_e                 state_q, state_d;
   logic                   cyc1_q, cyc1_d;
   logic [DW-1:0]          dev_q, dev_d, last_q, last_d;
   logic [15:0]            cap_dir_q, cap_dir_d, cap_out_q, cap_out_d;
   logic [NUM_DEV-1:0]     pend_init_q, pend_init_d, pend_rd_q, pend_rd_d;
   logic [NUM_DEV-1:0]     pend_wr_q, pend_wr_d, dev_err_q, dev_err_d;
   logic [NUM_DEV-1:0]     in_valid_q, in_valid_d, elig_q, elig_nxt;
   logic [16*NUM_DEV-1:0]  shadow_q, shadow_d, in_pins_q, in_pins_d;
   logic [6:0]             addr_q, addr_d;
   logic [1:0]             nwr_q, nwr_d, nrd_q, nrd_d;
   logic [7:0]             w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [SYNC_FF-1:0]     irq_sync_q;
   logic                   irq_prev_q, irq_fall;
   logic [31:0]            poll_cnt_q;
   logic                   poll_tick, txn, done_ok, found;
   int unsigned            sel, idx;

   // Synchronise the asynchronous INT line; idles high so reset never fakes an edge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         irq_sync_q <= '1;
         irq_prev_q <= 1'b1;
      end else begin
         irq_sync_q <= {irq_sync_q[SYNC_FF-2:0], irq_n_i};
         irq_prev_q <= irq_sync_q[SYNC_FF-1];
      end
   end

   assign irq_fall = irq_prev_q & ~irq_sync_q[SYNC_FF-1];

   // Free-running poll divider; a zero divider disables the tick entirely.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         poll_cnt_q <= '0;
      end else if (POLL_DIV != 0) begin
         poll_cnt_q <= poll_tick ? '0 : poll_cnt_q + 32'd1;
      end
   end

   assign poll_tick = (POLL_DIV != 0) && (poll_cnt_q == 32'(POLL_DIV - 1));
   assign elig_q    = (pend_init_q | pend_rd_q | pend_wr_q) & ~dev_err_q;
   assign txn       = (state_q != StIdle) && (state_q != StArb);
   // Done is ignored on the start cycle so a level-style done from the last transfer is not reused.
   assign done_ok   = txn && !cyc1_q && i2c_done_i;

   // Round-robin pick, starting one past the last serviced device.
   always_comb begin
      found = 1'b0;
      sel   = 0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_DEV; k++) begin
         idx = (32'(last_q) + k) % NUM_DEV;
         if (!found && elig_q[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   // Flag bookkeeping, FSM next state and transaction payload.
   always_comb begin
      state_d     = state_q;
      cyc1_d      = 1'b0;
      dev_d       = dev_q;
      last_d      = last_q;
      cap_dir_d   = cap_dir_q;
      cap_out_d   = cap_out_q;
      addr_d      = addr_q;
      nwr_d       = nwr_q;
      nrd_d       = nrd_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      pend_init_d = pend_init_q;
      pend_rd_d   = pend_rd_q;
      pend_wr_d   = pend_wr_q;
      dev_err_d   = dev_err_q;
      shadow_d    = shadow_q;
      in_pins_d   = in_pins_q;
      in_valid_d  = '0;

      for (int unsigned i = 0; i < NUM_DEV; i++) begin
         if (out_req_i[16*i +: 16] != shadow_q[16*i +: 16]) pend_wr_d[i] = 1'b1;
      end
      if (irq_fall || poll_tick) pend_rd_d = '1;

      if (done_ok) begin
         if (i2c_nack_i) begin
            dev_err_d[dev_q]   = 1'b1;
            pend_init_d[dev_q] = 1'b0;
            pend_rd_d[dev_q]   = 1'b0;
            pend_wr_d[dev_q]   = 1'b0;
         end else begin
            unique case (state_q)
               StInitMask: begin
                  pend_init_d[dev_q] = 1'b0;
                  pend_rd_d[dev_q]   = 1'b1;
                  pend_wr_d[dev_q]   = 1'b1;
               end
               StWrite: begin
                  shadow_d[16*dev_q +: 16] = cap_out_q;
                  // Keep the request pending if the pins moved again while on the bus.
                  if (out_req_i[16*dev_q +: 16] == cap_out_q) pend_wr_d[dev_q] = 1'b0;
               end
               StRdData: begin
                  in_pins_d[16*dev_q +: 16] = {rd_data1_i, rd_data0_i};
                  in_valid_d[dev_q]         = 1'b1;
                  pend_rd_d[dev_q]          = 1'b0;
               end
               default: ;
            endcase
         end
      end

      if (start_init_i) begin
         pend_init_d = '1;
         dev_err_d   = '0;
      end
      elig_nxt = (pend_init_d | pend_rd_d | pend_wr_d) & ~dev_err_d;

      unique case (state_q)
         StIdle: if (enable_i && (|elig_q)) state_d = StArb;
         StArb: begin
            if (!(|elig_q)) begin
               state_d = StIdle;
            end else if (enable_i) begin
               dev_d     = DW'(sel);
               last_d    = DW'(sel);
               addr_d    = dev_addr_i[7*sel +: 7];
               cap_dir_d = dir_inputs_i[16*sel +: 16];
               cap_out_d = out_req_i[16*sel +: 16];
               if (pend_init_q[sel])    state_d = StInitCfg;
               else if (pend_rd_q[sel]) state_d = StRdPtr;
               else                     state_d = StWrite;
            end
         end
         StInitCfg, StRdPtr: begin
            if (done_ok) begin
               if (!i2c_nack_i && enable_i)
                  state_d = (state_q == StInitCfg) ? StInitMask : StRdData;
               else
                  state_d = (|elig_nxt) ? StArb : StIdle;
            end
         end
         StInitMask, StWrite, StRdData: if (done_ok) state_d = (|elig_nxt) ? StArb : StIdle;
         default: state_d = StIdle;
      endcase

      // Payload is loaded once on entry and held until done.
      if (state_d != state_q) begin
         cyc1_d = 1'b1;
         unique case (state_d)
            StInitCfg: begin
               nwr_d = 2'd3; nrd_d = 2'd0;
               w0_d = 8'h06; w1_d = cap_dir_d[7:0]; w2_d = cap_dir_d[15:8];
            end
            StInitMask: begin
               nwr_d = 2'd3; nrd_d = 2'd0;
               w0_d = 8'h4A; w1_d = ~cap_dir_d[7:0]; w2_d = ~cap_dir_d[15:8];
            end
            StWrite: begin
               nwr_d = 2'd3; nrd_d = 2'd0;
               w0_d = 8'h02; w1_d = cap_out_d[7:0]; w2_d = cap_out_d[15:8];
            end
            StRdPtr: begin
               nwr_d = 2'd1; nrd_d = 2'd0;
               w0_d = 8'h00; w1_d = 8'h00; w2_d = 8'h00;
            end
            StRdData: begin
               nwr_d = 2'd0; nrd_d = 2'd2;
               w0_d = 8'h00; w1_d = 8'h00; w2_d = 8'h00;
            end
            default: cyc1_d = 1'b0;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         cyc1_q      <= 1'b0;
         dev_q       <= '0;
         last_q      <= DW'(NUM_DEV - 1);
         cap_dir_q   <= '0;
         cap_out_q   <= '0;
         addr_q      <= '0;
         nwr_q       <= '0;
         nrd_q       <= '0;
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         pend_init_q <= '1;
         pend_rd_q   <= '0;
         pend_wr_q   <= '0;
         dev_err_q   <= '0;
         shadow_q    <= '0;
         in_pins_q   <= '0;
         in_valid_q  <= '0;
      end else begin
         state_q     <= state_d;
         cyc1_q      <= cyc1_d;
         dev_q       <= dev_d;
         last_q      <= last_d;
         cap_dir_q   <= cap_dir_d;
         cap_out_q   <= cap_out_d;
         addr_q      <= addr_d;
         nwr_q       <= nwr_d;
         nrd_q       <= nrd_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         pend_init_q <= pend_init_d;
         pend_rd_q   <= pend_rd_d;
         pend_wr_q   <= pend_wr_d;
         dev_err_q   <= dev_err_d;
         shadow_q    <= shadow_d;
         in_pins_q   <= in_pins_d;
         in_valid_q  <= in_valid_d;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign i2c_start_o    = cyc1_q;
   assign i2c_addr_o     = addr_q;
   assign num_wr_bytes_o = nwr_q;
   assign num_rd_bytes_o = nrd_q;
   assign wr_data0_o     = w0_q;
   assign wr_data1_o     = w1_q;
   assign wr_data2_o     = w2_q;
   assign in_pins_o      = in_pins_q;
   assign in_valid_o     = in_valid_q;
   assign dev_err_o      = dev_err_q;

endmodule
